// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction width, jump opcodes and fetch actions.
package mips_pkg;

    localparam int          INST_W   = 32;
    localparam logic [5:0]  OPC_J    = 6'h02;
    localparam logic [5:0]  OPC_JAL  = 6'h03;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [2:0] {
        ACT_HALT,
        ACT_FAULT,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_JUMP,
        ACT_SEQ
    } fetch_act_e;

    function automatic logic is_jump(input logic [5:0] opc);
        return (opc == OPC_J) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Fetch-stage next-PC priority mux: fault halt, EX redirect, stall, early J/JAL, sequential.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter bit EARLY_JUMP_EN = 1'b1
) (
    input  logic              fault,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    input  logic [31:0]       pc,
    input  logic [INST_W-1:0] inst,
    output logic [31:0]       pc_next,
    output logic [31:0]       pc_plus4,
    output logic              pc_load,
    output logic              latch,
    output logic              squash,
    output logic              set_fault
);

    fetch_act_e act;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        // NOTE: every output gets a default first so no path through the priority chain infers a latch.
        act       = ACT_SEQ;
        pc_next   = pc_plus4;
        pc_load   = 1'b0;
        latch     = 1'b0;
        squash    = 1'b0;
        set_fault = 1'b0;

        if (fault) begin
            act = ACT_HALT;
        end else if (redirect_valid) begin
            act = (redirect_pc[1:0] != 2'b00) ? ACT_FAULT : ACT_REDIRECT;
        end else if (stall) begin
            act = ACT_STALL;
        end else if (EARLY_JUMP_EN && is_jump(inst[31:26])) begin
            act = ACT_JUMP;
        end

        case (act)
            ACT_HALT: begin
                squash = 1'b1;
            end
            ACT_FAULT: begin
                squash    = 1'b1;
                set_fault = 1'b1;
            end
            ACT_REDIRECT: begin
                squash  = 1'b1;
                pc_load = 1'b1;
                pc_next = redirect_pc;
            end
            ACT_JUMP: begin
                // Jump target keeps the top nibble of the delay-slot address.
                pc_load = 1'b1;
                latch   = 1'b1;
                pc_next = {pc_plus4[31:28], inst[25:0], 2'b00};
            end
            ACT_SEQ: begin
                pc_load = 1'b1;
                latch   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, drives combinational instruction memory and fills the IF/ID register.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          EARLY_JUMP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [31:0]       imem_pc,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_id_valid,
    output logic [INST_W-1:0] if_id_inst,
    output logic [31:0]       if_id_pc,
    output logic [31:0]       if_id_pc_plus4,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        pc_load;
    logic        latch;
    logic        squash;
    logic        set_fault;

    assign imem_pc = pc_q;

    next_pc_sel #(
        .EARLY_JUMP_EN (EARLY_JUMP_EN)
    ) u_next_pc_sel (
        .fault          (fetch_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .pc             (pc_q),
        .inst           (imem_inst),
        .pc_next        (pc_next),
        .pc_plus4       (pc_plus4),
        .pc_load        (pc_load),
        .latch          (latch),
        .squash         (squash),
        .set_fault      (set_fault)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q           <= RESET_PC;
            if_id_valid    <= 1'b0;
            if_id_inst     <= NOP_INST;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            fetch_fault    <= 1'b0;
            fetch_count    <= '0;
        end else begin
            if (pc_load) begin
                pc_q <= pc_next;
            end
            if (set_fault) begin
                fetch_fault <= 1'b1;
            end
            if (squash) begin
                if_id_valid <= 1'b0;
            end else if (latch) begin
                if_id_valid    <= 1'b1;
                if_id_inst     <= imem_inst;
                if_id_pc       <= pc_q;
                if_id_pc_plus4 <= pc_plus4;
                fetch_count    <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a behavioural fetch model checked every cycle,
// plus hand-computed literal expectations along a fixed program.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    instruction_fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .EARLY_JUMP_EN (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory: 64 words, address bits above 7 ignored.
    assign imem_inst = mem[imem_pc[7:2]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of the fetch stage.
    logic [31:0] m_pc, m_inst, m_ifpc, m_plus4, m_count;
    logic        m_valid, m_fault;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = 32'h0; m_inst = 32'h0; m_ifpc = 32'h0; m_plus4 = 32'h0;
            m_count = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else begin
            logic [31:0] w;
            w = mem_read(m_pc);
            if (m_fault) begin
                m_valid = 1'b0;
            end else if (redirect_valid) begin
                m_valid = 1'b0;
                if (redirect_pc % 4 != 0) m_fault = 1'b1;
                else                      m_pc = redirect_pc;
            end else if (!stall) begin
                m_inst  = w;
                m_ifpc  = m_pc;
                m_plus4 = m_pc + 32'd4;
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
                if (w[31:26] == 6'd2 || w[31:26] == 6'd3)
                    m_pc = (m_plus4 & 32'hF000_0000) | ({6'd0, w[25:0]} * 4);
                else
                    m_pc = m_plus4;
            end
        end
    end

    always @(negedge clk) begin
        check("imem_pc", imem_pc, m_pc);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
        check("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        check("fetch_count", fetch_count, m_count);
        if (m_valid) begin
            check("if_id_inst", if_id_inst, m_inst);
            check("if_id_pc", if_id_pc, m_ifpc);
            check("if_id_pc_plus4", if_id_pc_plus4, m_plus4);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]  = 32'h3409_0005;
        mem[1]  = 32'h340a_0005;
        mem[2]  = 32'h340b_0005;
        mem[3]  = 32'h340c_0005;
        mem[6]  = 32'hada9_0000;
        mem[7]  = 32'h0128_5020;
        mem[8]  = 32'h8d2b_0004;
        mem[9]  = 32'h0800_0014;  // j 0x50
        mem[10] = 32'h3c0b_dead;  // must never be fetched
        mem[20] = 32'h0c00_0018;  // jal 0x60
        mem[24] = 32'h0800_0018;  // j 0x60 (self-loop)

        reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick(2);
        check("rst_imem_pc", imem_pc, 32'h0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);

        // Two sequential fetches.
        reset_n = 1'b1;
        tick();
        check("e1_inst", if_id_inst, 32'h3409_0005);
        check("e1_pc", if_id_pc, 32'h0);
        check("e1_plus4", if_id_pc_plus4, 32'h4);
        tick();
        check("e2_inst", if_id_inst, 32'h340a_0005);
        check("e2_pc", if_id_pc, 32'h4);
        check("e2_count", fetch_count, 32'd2);

        // Stall holds everything.
        stall = 1'b1;
        tick(3);
        check("stall_pc", imem_pc, 32'h8);
        check("stall_inst", if_id_inst, 32'h340a_0005);
        check("stall_count", fetch_count, 32'd2);

        // Redirect overrides stall and squashes.
        redirect_valid = 1'b1; redirect_pc = 32'h18;
        tick();
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_pc", imem_pc, 32'h18);
        redirect_valid = 1'b0; stall = 1'b0;
        tick();
        check("redir_inst", if_id_inst, 32'hada9_0000);
        check("redir_ifpc", if_id_pc, 32'h18);

        // Early jump at 0x24 -> 0x50, then jal to 0x60 self-loop.
        tick(3);
        check("j_inst", if_id_inst, 32'h0800_0014);
        check("j_ifpc", if_id_pc, 32'h24);
        check("j_target", imem_pc, 32'h50);
        tick();
        check("after_j_pc", if_id_pc, 32'h50);
        check("jal_plus4", if_id_pc_plus4, 32'h54);
        tick(3);
        check("loop_pc", if_id_pc, 32'h60);
        check("loop_imem", imem_pc, 32'h60);
        check("loop_valid", {31'd0, if_id_valid}, 32'd1);
        check("loop_count", fetch_count, 32'd10);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", if_id_pc_plus4, 32'h0);
        check("wrap_imem", imem_pc, 32'h0);
        check("wrap_nop", if_id_inst, 32'h0);
        tick();
        check("wrap_count", fetch_count, 32'd12);

        // Misaligned redirect -> sticky fault until reset.
        redirect_valid = 1'b1; redirect_pc = 32'h1A;
        tick();
        check("fault_set", {31'd0, fetch_fault}, 32'd1);
        check("fault_valid", {31'd0, if_id_valid}, 32'd0);
        redirect_valid = 1'b0;
        tick(2);
        check("fault_frozen", imem_pc, 32'h4);
        check("fault_count", fetch_count, 32'd12);
        reset_n = 1'b0;
        #1;
        check("fault_clr", {31'd0, fetch_fault}, 32'd0);
        check("fault_rst_pc", imem_pc, 32'h0);
        tick();
        reset_n = 1'b1;

        // Async reset mid-cycle during stall.
        tick(2);
        stall = 1'b1;
        tick();
        check("pre_rst_count", fetch_count, 32'd2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_count", fetch_count, 32'd0);
        check("async_pc", imem_pc, 32'h0);
        check("async_inst", if_id_inst, 32'h0);
        tick();
        reset_n = 1'b1; stall = 1'b0;
        tick(2);
        check("post_rst_count", fetch_count, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
